fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Instruction-fetch controller for the 16x4 program memory. Owns the program counter.
//   Drives the memory address and waits out the memory's one-clock registered read.
//   Captures each opcode/data pair and presents it to execute through a valid/ready handshake.
//   Handles jumps, run/stop and a terminal halt opcode.
// PARAMETERS
//   ADDR_W       4        program-memory address width; PC wraps mod 2**ADDR_W
//   DATA_W       4        width of opcode and data words
//   RESET_PC     0        PC value loaded on reset; must be even
//   HALT_OPCODE  4'b1111  opcode that stops fetching once it is accepted
// PORTS
//   clk           in   1       system clock, all logic on posedge
//   reset         in   1       synchronous, active-high reset
//   run           in   1       fetch enable; sampled in IDLE and at handshake
//   mem_addr      out  ADDR_W  address to memory; always equals PC
//   mem_opcode    in   DATA_W  memory opcode output (memdata[addr])
//   mem_data      in   DATA_W  memory data output (memdata[addr+1])
//   instr_valid   out  1       instr_* fields hold a fetched instruction
//   instr_ready   in   1       execute accepts the instruction this cycle
//   instr_opcode  out  DATA_W  captured opcode
//   instr_data    out  DATA_W  captured data word
//   instr_pc      out  ADDR_W  PC the instruction was fetched from
//   jump_valid    in   1       redirect request; honoured only on accepted handshake
//   jump_addr     in   ADDR_W  jump target; LSB forced to 0
//   busy          out  1       state is ISSUE, CAPTURE or HOLD
//   halted        out  1       HALT_OPCODE was accepted; fetch stopped
// BEHAVIOUR
//   Reset (sync, high): state=IDLE, pc=RESET_PC, instr_valid=0, instr_opcode/data/pc=0,
//     busy=0, halted=0. Reset overrides everything, including a mid-fetch or HOLD state.
//   FSM states: IDLE, ISSUE, CAPTURE, HOLD, HALT.
//     IDLE    : run=1 -> ISSUE; otherwise stay in IDLE.
//     ISSUE   : mem_addr=pc is presented; memory latches at the edge -> CAPTURE.
//     CAPTURE : mem_opcode/mem_data are valid; at the edge register them into instr_*,
//               set instr_pc=pc and instr_valid=1 -> HOLD.
//     HOLD    : instr_valid=1 and instr_* held stable until instr_ready=1.
//               On accept, instr_valid drops at the next edge, then:
//                 1. opcode==HALT_OPCODE -> HALT. Jump and run are ignored.
//                 2. Otherwise, next pc = jump_valid ? {jump_addr[ADDR_W-1:1],1'b0} : pc+2 (wraps).
//                 3. run=1 -> ISSUE; run=0 -> IDLE with the new pc retained.
//     HALT    : halted=1, instr_valid=0; left only by reset.
//   Timing: first instr_valid rises on the 3rd posedge after run is sampled high in IDLE.
//     Peak throughput is 1 instruction per 3 cycles with instr_ready held high.
//   mem_addr = pc at all times. The pc changes only on an accepted handshake or on reset,
//     so the address is stable across ISSUE, CAPTURE and HOLD.
//   Arithmetic: pc+2 is modulo 2**ADDR_W (14+2 -> 0). The memory's addr+1 wrap at 15
//     is the memory's concern.
//   run deasserted during ISSUE/CAPTURE/HOLD does not abort the fetch in flight.
//     It takes effect only at the handshake.
//   jump_valid outside an accepted handshake is ignored; no request is latched.
//   Odd jump targets are aligned down to even (jump_addr=9 -> pc=8).
//   instr_* are not cleared on accept; they keep their last value while instr_valid=0.
// TESTING (memory model with the program image: mem[1]=1100, mem[3]=1111, mem[9]=1100)
//   1. Reset, run=1, ready=1 -> valid on 3rd edge with pc=0, op=0000, data=1100;
//      next fetch pc=2, data=1111; valid pulses every 3 cycles.
//   2. Hold ready=0 for 5 cycles in HOLD -> instr_* and mem_addr stable, valid stays 1;
//      on ready=1, pc advances by exactly 2.
//   3. Accept with jump_valid=1, jump_addr=9 -> next instr_pc=8, instr_data=1100;
//      jump_valid pulsed during CAPTURE has no effect.
//   4. Let pc reach 14 and accept -> next instr_pc=0 (wrap), no glitch on mem_addr.
//   5. Patch mem[4]=1111 (HALT) and accept at pc=4 -> halted=1, valid never rises again,
//      run toggling has no effect; reset -> halted=0, pc=0, IDLE.
//   6. Assert reset during CAPTURE and then during HOLD -> the next cycle shows valid=0,
//      pc=RESET_PC, busy=0; with run=1, fetch restarts from pc 0.
//   7. Drop run at the handshake -> IDLE with pc=2 retained; raising run again fetches pc 2.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Function : Program-counter owner and fetch controller for the 16x4 program
//            memory; presents opcode/data pairs to execute via valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                 ADDR_W      = 4,
  parameter int                 DATA_W      = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [DATA_W-1:0]  HALT_OPCODE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_opcode,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic              w_accept;
  logic              w_is_halt;
  logic [ADDR_W-1:0] w_jump_target;

  assign w_accept      = (state_q == S_HOLD) && instr_ready;
  assign w_is_halt     = (opcode_q == HALT_OPCODE);
  // Masking rather than slicing keeps every jump_addr bit in use.
  assign w_jump_target = jump_addr & ~ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= '0;
      data_q   <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        opcode_d = mem_opcode;
        data_d   = mem_data;
        ipc_d    = pc_q;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (w_accept) begin
          if (w_is_halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = jump_valid ? w_jump_target : pc_q + ADDR_W'(2);
            state_d = run ? S_ISSUE : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    instr_valid = (state_q == S_HOLD);
    busy        = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_HOLD);
    halted      = (state_q == S_HALT);
  end

  assign mem_addr     = pc_q;
  assign instr_opcode = opcode_q;
  assign instr_data   = data_q;
  assign instr_pc     = ipc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Function : Directed self-checking bench for fetch_sequencer with a
//            registered-read 16x4 program memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] mem_addr;
  logic [3:0] mem_opcode;
  logic [3:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_opcode;
  logic [3:0] instr_data;
  logic [3:0] instr_pc;
  logic       jump_valid;
  logic [3:0] jump_addr;
  logic       busy;
  logic       halted;

  logic [3:0] mem [16];
  logic [3:0] w_next_addr;

  int checks = 0;
  int errors = 0;
  int n;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_opcode   (mem_opcode),
    .mem_data     (mem_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .jump_valid   (jump_valid),
    .jump_addr    (jump_addr),
    .busy         (busy),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Memory with a one-clock registered read; data word comes from addr+1 mod 16.
  assign w_next_addr = mem_addr + 4'd1;
  always @(posedge clk) begin
    mem_opcode <= mem[mem_addr];
    mem_data   <= mem[w_next_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!instr_valid && cnt < budget);
    check_value("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem[1] = 4'b1100;
    mem[3] = 4'b1111;
    mem[9] = 4'b1100;
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = 4'd0;
    tick(); tick();

    // Reset state
    check_value("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_halted", {31'd0, halted}, 32'd0);
    check_value("rst_addr", {28'd0, mem_addr}, 32'd0);
    check_value("rst_ipc", {28'd0, instr_pc}, 32'd0);
    check_value("rst_op", {28'd0, instr_opcode}, 32'd0);

    // 1: first fetch lands on the 3rd edge, then every 3 cycles
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    wait_valid(10, n);
    check_value("t1_lat", n, 32'd3);
    check_value("t1_pc0", {28'd0, instr_pc}, 32'd0);
    check_value("t1_op0", {28'd0, instr_opcode}, 32'h0);
    check_value("t1_data0", {28'd0, instr_data}, 32'hC);
    wait_valid(10, n);
    check_value("t1_period", n, 32'd3);
    check_value("t1_pc2", {28'd0, instr_pc}, 32'd2);
    check_value("t1_data2", {28'd0, instr_data}, 32'hF);

    // 2: stall in HOLD for 5 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("t2_valid", {31'd0, instr_valid}, 32'd1);
      check_value("t2_pc", {28'd0, instr_pc}, 32'd2);
      check_value("t2_data", {28'd0, instr_data}, 32'hF);
      check_value("t2_addr", {28'd0, mem_addr}, 32'd2);
    end
    instr_ready = 1'b1;
    tick();
    check_value("t2_drop", {31'd0, instr_valid}, 32'd0);
    check_value("t2_adv", {28'd0, mem_addr}, 32'd4);
    wait_valid(10, n);
    check_value("t2_pc4", {28'd0, instr_pc}, 32'd4);

    // 3: jump to odd 9 aligns to 8; jump during CAPTURE ignored
    jump_valid = 1'b1; jump_addr = 4'd9;
    tick();
    jump_valid = 1'b0;
    check_value("t3_jaddr", {28'd0, mem_addr}, 32'd8);
    tick();
    jump_valid = 1'b1; jump_addr = 4'd6;
    tick();
    jump_valid = 1'b0;
    check_value("t3_valid", {31'd0, instr_valid}, 32'd1);
    check_value("t3_pc", {28'd0, instr_pc}, 32'd8);
    check_value("t3_data", {28'd0, instr_data}, 32'hC);
    tick();
    check_value("t3_nojump", {28'd0, mem_addr}, 32'd10);

    // 4: wrap from 14 to 0
    wait_valid(10, n);
    check_value("t4_pc10", {28'd0, instr_pc}, 32'd10);
    wait_valid(10, n);
    check_value("t4_pc12", {28'd0, instr_pc}, 32'd12);
    wait_valid(10, n);
    check_value("t4_pc14", {28'd0, instr_pc}, 32'd14);
    check_value("t4_addr14", {28'd0, mem_addr}, 32'd14);
    tick();
    check_value("t4_wrap", {28'd0, mem_addr}, 32'd0);
    wait_valid(10, n);
    check_value("t4_pc0", {28'd0, instr_pc}, 32'd0);
    check_value("t4_data0", {28'd0, instr_data}, 32'hC);

    // 7: drop run at handshake, pc 2 retained
    run = 1'b0;
    tick();
    check_value("t7_valid", {31'd0, instr_valid}, 32'd0);
    check_value("t7_busy", {31'd0, busy}, 32'd0);
    check_value("t7_addr", {28'd0, mem_addr}, 32'd2);
    tick(); tick();
    check_value("t7_idle", {31'd0, busy}, 32'd0);
    run = 1'b1;
    wait_valid(10, n);
    check_value("t7_lat", n, 32'd3);
    check_value("t7_pc", {28'd0, instr_pc}, 32'd2);
    check_value("t7_data", {28'd0, instr_data}, 32'hF);

    // 6: reset during CAPTURE, then during HOLD
    tick(); tick();
    check_value("t6_inflight", {28'd0, mem_addr}, 32'd4);
    reset = 1'b1;
    tick();
    check_value("t6c_valid", {31'd0, instr_valid}, 32'd0);
    check_value("t6c_busy", {31'd0, busy}, 32'd0);
    check_value("t6c_addr", {28'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    wait_valid(10, n);
    check_value("t6c_lat", n, 32'd3);
    check_value("t6c_pc", {28'd0, instr_pc}, 32'd0);
    check_value("t6c_data", {28'd0, instr_data}, 32'hC);
    reset = 1'b1;
    tick();
    check_value("t6h_valid", {31'd0, instr_valid}, 32'd0);
    check_value("t6h_busy", {31'd0, busy}, 32'd0);
    check_value("t6h_addr", {28'd0, mem_addr}, 32'd0);
    check_value("t6h_data", {28'd0, instr_data}, 32'h0);
    reset = 1'b0;

    // 5: HALT opcode at pc 4
    mem[4] = 4'b1111;
    wait_valid(10, n);
    check_value("t5_pc0", {28'd0, instr_pc}, 32'd0);
    wait_valid(10, n);
    check_value("t5_pc2", {28'd0, instr_pc}, 32'd2);
    wait_valid(10, n);
    check_value("t5_pc4", {28'd0, instr_pc}, 32'd4);
    check_value("t5_op", {28'd0, instr_opcode}, 32'hF);
    tick();
    check_value("t5_halted", {31'd0, halted}, 32'd1);
    check_value("t5_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      run = i[0];
      tick();
      check_value("t5_novalid", {31'd0, instr_valid}, 32'd0);
      check_value("t5_stay", {31'd0, halted}, 32'd1);
      check_value("t5_addr", {28'd0, mem_addr}, 32'd4);
    end
    run = 1'b1;
    reset = 1'b1;
    tick();
    check_value("t5r_halted", {31'd0, halted}, 32'd0);
    check_value("t5r_addr", {28'd0, mem_addr}, 32'd0);
    check_value("t5r_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_valid(10, n);
    check_value("t5r_pc", {28'd0, instr_pc}, 32'd0);
    check_value("t5r_data", {28'd0, instr_data}, 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
